ad9228_serial_tx: RTL and testbench

AD9228_SERIAL_TX -- requirements
Module: ad9228_serial_tx

---
 rtl/ad9228_pkg.sv | 27 ++
 rtl/ad9228_serial_tx_if.sv | 22 ++
 rtl/ad9228_pattern_gen.sv | 57 +++++
 rtl/ad9228_serial_tx.sv | 119 +++++++++++
 tb/tb_ad9228_serial_tx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ad9228_pkg.sv
// AD9228-style serial LVDS transmitter: shared types and pattern words.
// Pattern words are stored at MAX_W and cut down to the frame width.
package ad9228_pkg;

  typedef enum logic [2:0] {
    MODE_DATA     = 3'd0,
    MODE_MIDSCALE = 3'd1,
    MODE_POS_FS   = 3'd2,
    MODE_NEG_FS   = 3'd3,
    MODE_CHECKER  = 3'd4,
    MODE_TOGGLE   = 3'd5,
    MODE_RSVD6    = 3'd6,
    MODE_RSVD7    = 3'd7
  } ad9228_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ad9228_state_t;

  localparam int MAX_W = 32;

  localparam logic [MAX_W-1:0] MIDSCALE  = 32'h8000_0000;
  localparam logic [MAX_W-1:0] CHECKER_A = 32'hAAAA_AAAA;
  localparam logic [MAX_W-1:0] CHECKER_B = 32'h5555_5555;

endpackage

// File: rtl/ad9228_serial_tx_if.sv
// Sample stream into the serializer: valid/ready handshake.
interface ad9228_serial_tx_if #(
  parameter int DATA_WIDTH = 12
) ();

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/ad9228_pattern_gen.sv
// Per-frame word select, including checker/toggle phase tracking.
import ad9228_pkg::*;

module ad9228_pattern_gen #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  ad9228_mode_t          mode,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam logic [DATA_WIDTH-1:0] MID =
    DATA_WIDTH'(MIDSCALE >> (MAX_W - DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] CHK_A =
    DATA_WIDTH'(CHECKER_A);
  localparam logic [DATA_WIDTH-1:0] CHK_B =
    DATA_WIDTH'(CHECKER_B);

  logic         phase_q, phase_d;
  logic         alt;
  ad9228_mode_t last_mode_q, last_mode_d;

  always_comb begin
    // a mode change restarts the alternation at its first word
    alt         = (mode == last_mode_q) ? phase_q : 1'b0;
    phase_d     = phase_q;
    last_mode_d = last_mode_q;
    if (load) begin
      phase_d     = ~alt;
      last_mode_d = mode;
    end
    word = MID;
    case (mode)
      MODE_DATA:    word = s_valid ? s_data : MID;
      MODE_POS_FS:  word = '1;
      MODE_NEG_FS:  word = '0;
      MODE_CHECKER: word = alt ? CHK_B : CHK_A;
      MODE_TOGGLE:  word = alt ? '0 : '1;
      default:      word = MID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= 1'b0;
      last_mode_q <= MODE_DATA;
    end else begin
      phase_q     <= phase_d;
      last_mode_q <= last_mode_d;
    end
  end

endmodule

// File: rtl/ad9228_serial_tx.sv
// Frame serializer: one bit per clk, gap-free frames, registered outputs.
import ad9228_pkg::*;

module ad9228_serial_tx #(
  parameter int DATA_WIDTH    = 12,
  parameter int DOUT_INVERTED = 0,
  parameter int LSB_FIRST     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  ad9228_mode_t        mode,
  ad9228_serial_tx_if.slave   s,
  output logic                sdata,
  output logic                fco,
  output logic                frame_start,
  output logic                underflow,
  output logic [15:0]         underflow_cnt
);

  localparam int CW =
    (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic INV = (DOUT_INVERTED != 0);
  localparam bit   LSB = (LSB_FIRST != 0);

  ad9228_state_t         state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  sdata_q, sdata_d;
  logic                  fco_q, fco_d;
  logic                  fs_q, fs_d;
  logic                  ufl_q, ufl_d;
  logic [15:0]           underflow_cnt_q, underflow_cnt_d;

  logic                  load;
  logic                  data_load;
  logic [DATA_WIDTH-1:0] word;
  logic                  first_bit;
  logic                  next_bit;

  ad9228_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pat (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .mode    (mode),
    .s_data  (s.s_data),
    .s_valid (s.s_valid),
    .word    (word)
  );

  assign s.s_ready = data_load && !rst;

  always_comb begin
    load = enable &&
      (state_q == ST_IDLE ||
       (state_q == ST_RUN && bit_cnt_q == LAST));
    data_load = load && (mode == MODE_DATA);
    first_bit = LSB ? word[0] : word[DATA_WIDTH-1];
    next_bit  = LSB ? sreg_q[0] : sreg_q[DATA_WIDTH-1];

    state_d   = ST_IDLE;
    bit_cnt_d = '0;
    sreg_d    = sreg_q;
    sdata_d   = 1'b0;
    fco_d     = 1'b0;
    fs_d      = 1'b0;
    ufl_d     = data_load && !s.s_valid;
    underflow_cnt_d = underflow_cnt_q;
    if (ufl_d && underflow_cnt_q != 16'hFFFF)
      underflow_cnt_d = underflow_cnt_q + 16'd1;

    // bit 0 goes straight to the output flop; sreg holds the rest
    if (load) begin
      state_d = ST_RUN;
      sreg_d  = LSB ? (word >> 1) : (word << 1);
      sdata_d = first_bit ^ INV;
      fco_d   = 1'b1;
      fs_d    = 1'b1;
    end else if (state_q == ST_RUN && bit_cnt_q != LAST) begin
      state_d   = ST_RUN;
      bit_cnt_d = bit_cnt_q + 1'b1;
      sreg_d    = LSB ? (sreg_q >> 1) : (sreg_q << 1);
      sdata_d   = next_bit ^ INV;
      fco_d     = int'(bit_cnt_d) < (DATA_WIDTH / 2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      sreg_q          <= '0;
      sdata_q         <= 1'b0;
      fco_q           <= 1'b0;
      fs_q            <= 1'b0;
      ufl_q           <= 1'b0;
      underflow_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      sreg_q          <= sreg_d;
      sdata_q         <= sdata_d;
      fco_q           <= fco_d;
      fs_q            <= fs_d;
      ufl_q           <= ufl_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  assign sdata         = sdata_q;
  assign fco           = fco_q;
  assign frame_start   = fs_q;
  assign underflow     = ufl_q;
  assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_ad9228_serial_tx.sv
// Directed bench for ad9228_serial_tx: default and LSB/inverted builds.
module tb_ad9228_serial_tx;
  import ad9228_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en1, en2;
  ad9228_mode_t mode1, mode2;
  logic sd1, fco1, fs1, uf1;
  logic sd2, fco2, fs2, uf2;
  logic [15:0] uc1, uc2;

  int checks = 0;
  int failures = 0;

  ad9228_serial_tx_if #(.DATA_WIDTH(12)) bus1 ();
  ad9228_serial_tx_if #(.DATA_WIDTH(12)) bus2 ();

  ad9228_serial_tx #(
    .DATA_WIDTH(12), .DOUT_INVERTED(0), .LSB_FIRST(0)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .mode(mode1),
    .s(bus1), .sdata(sd1), .fco(fco1),
    .frame_start(fs1), .underflow(uf1),
    .underflow_cnt(uc1)
  );

  ad9228_serial_tx #(
    .DATA_WIDTH(12), .DOUT_INVERTED(1), .LSB_FIRST(1)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .mode(mode2),
    .s(bus2), .sdata(sd2), .fco(fco2),
    .frame_start(fs2), .underflow(uf2),
    .underflow_cnt(uc2)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // collects one MSB-first frame from dut1, counting underflow pulses
  task automatic get_word(output logic [11:0] w,
                          output int nu);
    w  = '0;
    nu = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check("gw_frame_start", fs1, 1);
      check("gw_fco", fco1, (i < 6));
      w = {w[10:0], sd1};
      if (uf1) nu++;
    end
  endtask

  logic [11:0] w, exp;
  int nu, nu_tot;

  initial begin
    rst = 1'b1; en1 = 1'b1; en2 = 1'b0;
    mode1 = MODE_DATA; mode2 = MODE_DATA;
    bus1.s_data = '0; bus1.s_valid = 1'b0;
    bus2.s_data = '0; bus2.s_valid = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_ready", bus1.s_ready, 0);
    check("rst_sdata", sd1, 0);
    check("rst_fco", fco1, 0);
    check("rst_fs", fs1, 0);
    check("rst_ufl", uf1, 0);
    check("rst_ucnt", uc1, 0);
    en1 = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_sdata", sd1, 0);

    // MSB-first DATA frame 0xABC, back-to-back second frame
    bus1.s_data = 12'hABC; bus1.s_valid = 1'b1;
    en1 = 1'b1;
    #1;
    check("data_ready", bus1.s_ready, 1);
    exp = 12'hABC;
    for (int i = 1; i <= 13; i++) begin
      tick();
      check("abc_fs", fs1, (i == 1 || i == 13));
      if (i <= 12) begin
        check("abc_bit", sd1, exp[12-i]);
        check("abc_fco", fco1, (i <= 6));
      end
      if (i == 1) check("abc_ufl", uf1, 0);
    end
    en1 = 1'b0;
    repeat (11) tick();
    tick();
    check("abc_idle_sd", sd1, 0);
    check("abc_idle_fco", fco1, 0);

    // LSB-first, inverted build, sample 0x001
    bus2.s_data = 12'h001; bus2.s_valid = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        en2 = 1'b0;
        check("inv_fs", fs2, 1);
      end
      check("inv_bit", sd2, (i != 0));
      check("inv_fco", fco2, (i < 6));
    end
    tick();
    check("inv_idle_sd", sd2, 0);

    // checker x3 then toggle x2
    mode1 = MODE_CHECKER;
    en1 = 1'b1;
    get_word(w, nu); check("chk0", w, 12'hAAA);
    get_word(w, nu); check("chk1", w, 12'h555);
    get_word(w, nu); check("chk2", w, 12'hAAA);
    mode1 = MODE_TOGGLE;
    get_word(w, nu); check("tog0", w, 12'hFFF);
    get_word(w, nu); check("tog1", w, 12'h000);
    en1 = 1'b0;
    tick();
    check("pat_idle_fs", fs1, 0);

    // underflow: three DATA loads without a sample
    mode1 = MODE_DATA;
    bus1.s_valid = 1'b0;
    en1 = 1'b1;
    #1;
    check("ufl_ready", bus1.s_ready, 1);
    nu_tot = 0;
    for (int k = 0; k < 3; k++) begin
      get_word(w, nu);
      check("ufl_word", w, 12'h800);
      nu_tot += nu;
    end
    en1 = 1'b0;
    check("ufl_pulses", nu_tot, 3);
    check("ufl_cnt", uc1, 3);
    tick();
    force dut1.underflow_cnt_q = 16'hFFFD;
    tick();
    release dut1.underflow_cnt_q;
    tick();
    check("sat_preset", uc1, 16'hFFFD);
    en1 = 1'b1;
    get_word(w, nu);
    check("sat_pulse", nu, 1);
    check("sat_cnt0", uc1, 16'hFFFE);
    get_word(w, nu);
    check("sat_cnt1", uc1, 16'hFFFF);
    get_word(w, nu);
    check("sat_cnt2", uc1, 16'hFFFF);
    check("sat_word", w, 12'h800);
    en1 = 1'b0;
    tick();

    // enable drops at bit 3, frame still completes
    bus1.s_valid = 1'b1;
    bus1.s_data = 12'h5A3;
    en1 = 1'b1;
    w = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check("drop_fs", fs1, 1);
      w = {w[10:0], sd1};
      if (i == 3) en1 = 1'b0;
    end
    check("drop_word", w, 12'h5A3);
    tick();
    check("drop_idle_sd", sd1, 0);
    check("drop_idle_fco", fco1, 0);
    check("drop_idle_fs", fs1, 0);
    tick();
    tick();
    bus1.s_data = 12'h3C5;
    en1 = 1'b1;
    get_word(w, nu);
    check("reen_word", w, 12'h3C5);
    en1 = 1'b0;
    tick();

    // reset mid-frame at bit 5
    bus1.s_data = 12'hFFF;
    en1 = 1'b1;
    repeat (6) tick();
    check("mid_bit5", sd1, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_sd", sd1, 0);
    check("mid_rst_fco", fco1, 0);
    check("mid_rst_fs", fs1, 0);
    check("mid_rst_ufl", uf1, 0);
    check("mid_rst_cnt", uc1, 0);
    bus1.s_data = 12'h9C3;
    rst = 1'b0;
    get_word(w, nu);
    check("post_rst_word", w, 12'h9C3);
    en1 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
